// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU class codes, function codes and FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_core.sv
// ============================================================================
// Module : alu_muldiv_core
// Brief  : Iterative unsigned shift-add multiplier / restoring divider,
//          one bit per cycle, WIDTH iterations per operation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r0_q, r0_d;   // accumulator / partial remainder
  logic [WIDTH-1:0] r1_q, r1_d;   // multiplier / quotient
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             op_q, op_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q   <= '0;
      r1_q   <= '0;
      opb_q  <= '0;
      op_q   <= MD_MUL;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      r0_q   <= r0_d;
      r1_q   <= r1_d;
      opb_q  <= opb_d;
      op_q   <= op_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // lo/hi expose the post-iteration values so the parent can capture the
  // final result on the same edge that retires the last iteration.
  always_comb begin
    r0_d    = r0_q;
    r1_d    = r1_q;
    opb_d   = opb_q;
    op_d    = op_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    w_sum   = {1'b0, r0_q} + {1'b0, opb_q & {WIDTH{r1_q[0]}}};
    w_shift = {r0_q, r1_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, opb_q};
    if (start) begin
      r0_d   = '0;
      r1_d   = a;
      opb_d  = b;
      op_d   = op;
      busy_d = 1'b1;
      cnt_d  = CW'(WIDTH);
    end else if (busy_q) begin
      if (op_q == MD_MUL) begin
        r0_d = w_sum[WIDTH:1];
        r1_d = {w_sum[0], r1_q[WIDTH-1:1]};
      end else if (!w_diff[WIDTH]) begin
        r0_d = w_diff[WIDTH-1:0];
        r1_d = {r1_q[WIDTH-2:0], 1'b1};
      end else begin
        r0_d = w_shift[WIDTH-1:0];
        r1_d = {r1_q[WIDTH-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
    busy = busy_q;
    done = busy_q && (cnt_q == CW'(1));
    lo   = r1_d;
    hi   = r0_d;
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module : alu_exec_unit
// Brief  : ALU execution unit with IDLE/RUN/DONE sequencing. Define
//          ALU_MULDIV_EN to build in MULTU/DIVU and the RUN state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] w_sum, w_diff, w_res, w_hi;
  logic             w_add_ovf, w_sub_ovf, w_ovf, w_ill, w_dz, w_run, w_zero;

`ifdef ALU_MULDIV_EN
  logic             w_core_busy, w_core_done;
  logic [WIDTH-1:0] w_core_lo, w_core_hi;

  alu_muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start ((state_q == ST_IDLE) && start && w_run),
    .op    ((func == FUNC_DIVU) ? MD_DIV : MD_MUL),
    .a     (a),
    .b     (b),
    .busy  (w_core_busy),
    .done  (w_core_done),
    .lo    (w_core_lo),
    .hi    (w_core_hi)
  );
`endif

  always_comb begin
    w_sum     = a + b;
    w_diff    = a - b;
    w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    w_res = '0;
    w_hi  = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    w_dz  = 1'b0;
    w_run = 1'b0;
    case (alu_op)
      ALUOP_ADD: begin w_res = w_sum;  w_ovf = w_add_ovf; end
      ALUOP_SUB: begin w_res = w_diff; w_ovf = w_sub_ovf; end
      default: begin
        case (func)
          FUNC_ADD:  begin w_res = w_sum;  w_ovf = w_add_ovf; end
          FUNC_SUB:  begin w_res = w_diff; w_ovf = w_sub_ovf; end
          FUNC_AND:  w_res = a & b;
          FUNC_OR:   w_res = a | b;
          FUNC_XOR:  w_res = a ^ b;
          FUNC_NOR:  w_res = ~(a | b);
          FUNC_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          FUNC_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_MULDIV_EN
          FUNC_MULTU: w_run = 1'b1;
          FUNC_DIVU: begin
            if (b == '0) begin
              w_dz  = 1'b1;
              w_res = '1;
              w_hi  = a;
            end else begin
              w_run = 1'b1;
            end
          end
`endif
          default:   w_ill = 1'b1;
        endcase
      end
    endcase
    w_zero = !w_ill && (w_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      div0_q    <= div0_d;
    end
  end

  // Result registers only change on an accepted start or on multi-cycle
  // completion, so outputs hold from done until the next launch.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    div0_d    = div0_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (w_run) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_DONE;
            result_d  = w_res;
            hi_d      = w_hi;
            zero_d    = w_zero;
            ovf_d     = w_ovf;
            illegal_d = w_ill;
            div0_d    = w_dz;
          end
        end
      end
`ifdef ALU_MULDIV_EN
      ST_RUN: begin
        if (w_core_done) begin
          state_d   = ST_DONE;
          result_d  = w_core_lo;
          hi_d      = w_core_hi;
          zero_d    = (w_core_lo == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
          div0_d    = 1'b0;
        end else if (!w_core_busy) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    result  = result_q;
    hi      = hi_q;
    zero    = zero_q;
    ovf     = ovf_q;
    illegal = illegal_q;
    div0    = div0_q;
  end

endmodule

`default_nettype wire
